// File: rtl/wb_dsp_vector_engine.sv
// Wishbone classic bus-master vector engine.
// Fetches a 4-word descriptor (A base, B base, C base, length), streams A and B,
// applies the latched op and writes C back (or a single MAC result to C base).
// Each transfer holds stb until ack/err/rty; cyc/stb drop for one cycle between transfers.
//
// state  | meaning
// IDLE   | waiting for a start edge
// DESC   | reading the four descriptor words
// RD_A   | reading A[i]
// RD_B   | reading B[i] (skipped for COPY)
// EXEC   | one-cycle arithmetic on the captured operands
// WR_C   | writing C[i] (or the MAC sum once)
// DONE   | one cycle to flag completion, then IDLE
module wb_dsp_vector_engine #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int LEN_W     = 16,
    parameter int RETRY_MAX = 3
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic [dw-1:0] equation_address_reg,
    input  logic [dw-1:0] control_reg,
    output logic [dw-1:0] status_reg
);

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_SUB  = 8'd1;
    localparam logic [7:0] OP_MUL  = 8'd2;
    localparam logic [7:0] OP_MAC  = 8'd3;
    localparam logic [7:0] OP_COPY = 8'd4;
    localparam int RW = $clog2(RETRY_MAX + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_DESC, S_RD_A, S_RD_B, S_EXEC, S_WR_C, S_DONE
    } state_t;

    state_t state, state_nxt, ack_nxt;

    logic             start_q, stop_q, stop_pend;
    logic [7:0]       op_q;
    logic [aw-1:0]    desc_base, a_base, b_base, c_base;
    logic [LEN_W-1:0] len_q, elem_idx, idx_inc;
    logic [1:0]       desc_idx;
    logic [dw-1:0]    a_val, b_val, acc, result_q, prod, exec_val;
    logic [RW-1:0]    retry_cnt;
    logic [15:0]      cnt;
    logic             stb_q, we_q;
    logic [aw-1:0]    adr_q, issue_adr, idx_off, desc_off;
    logic [dw-1:0]    dat_q;
    logic             done_q, err_q, abort_q;

    logic start_rise, stop_rise, stop_req, op_ok, is_mac, is_copy, last_elem, ack_hit;
    logic accept, bad_op, issue, set_err, set_abort, set_done, retry_inc, do_exec;

    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, control_reg[dw-1:16], control_reg[7:2]};

    assign start_rise = control_reg[0] & ~start_q;
    assign stop_rise  = control_reg[1] & ~stop_q;
    assign stop_req   = stop_pend | stop_rise;
    assign op_ok      = control_reg[15:8] <= OP_COPY;
    assign is_mac     = op_q == OP_MAC;
    assign is_copy    = op_q == OP_COPY;
    assign idx_inc    = elem_idx + LEN_W'(1);
    assign last_elem  = idx_inc == len_q;
    assign ack_hit    = stb_q & wb_ack_i;
    assign idx_off    = aw'(elem_idx) << 2;
    assign desc_off   = aw'(desc_idx) << 2;
    assign prod       = a_val * b_val;

    // Arithmetic result for the current element (all modulo 2^dw)
    always_comb begin
        exec_val = a_val;
        case (op_q)
            OP_ADD:  exec_val = a_val + b_val;
            OP_SUB:  exec_val = a_val - b_val;
            OP_MUL:  exec_val = prod;
            OP_MAC:  exec_val = acc + prod;
            default: exec_val = a_val;
        endcase
    end

    // Where an acked transfer leads, and the address of the next transfer to issue
    always_comb begin
        ack_nxt   = state;
        issue_adr = '0;
        case (state)
            S_IDLE: issue_adr = aw'(equation_address_reg);
            S_DESC: begin
                issue_adr = desc_base + desc_off;
                if (desc_idx == 2'd3)
                    ack_nxt = (wb_dat_i[LEN_W-1:0] == '0) ? S_DONE : S_RD_A;
            end
            S_RD_A: begin
                issue_adr = a_base + idx_off;
                ack_nxt   = is_copy ? S_EXEC : S_RD_B;
            end
            S_RD_B: begin
                issue_adr = b_base + idx_off;
                ack_nxt   = S_EXEC;
            end
            S_WR_C: begin
                issue_adr = is_mac ? c_base : c_base + idx_off;
                ack_nxt   = (is_mac || last_elem) ? S_DONE : S_RD_A;
            end
            default: ;
        endcase
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bad_op    = 1'b0;
        issue     = 1'b0;
        set_err   = 1'b0;
        set_abort = 1'b0;
        set_done  = 1'b0;
        retry_inc = 1'b0;
        do_exec   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_rise && !stop_rise) begin
                    if (op_ok) begin
                        accept    = 1'b1;
                        issue     = 1'b1;
                        state_nxt = S_DESC;
                    end else begin
                        bad_op = 1'b1;
                    end
                end
            end
            S_DONE: begin
                set_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                if (ack_hit) begin
                    if (stop_req) begin
                        set_abort = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = ack_nxt;
                    end
                end else if (stb_q && wb_err_i) begin
                    set_err   = 1'b1;
                    set_abort = stop_req;
                    state_nxt = S_IDLE;
                end else if (stb_q && wb_rty_i) begin
                    if (stop_req) begin
                        set_abort = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (retry_cnt == RW'(RETRY_MAX)) begin
                        set_err   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        retry_inc = 1'b1;
                    end
                end else if (stb_q) begin
                    state_nxt = state;
                end else if (stop_req) begin
                    set_abort = 1'b1;
                    state_nxt = S_IDLE;
                end else if (state == S_EXEC) begin
                    do_exec   = 1'b1;
                    state_nxt = (is_mac && !last_elem) ? S_RD_A : S_WR_C;
                end else begin
                    issue = 1'b1;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Bus master registers, descriptor capture, datapath and sticky status
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            stop_pend <= 1'b0;
            op_q      <= '0;
            desc_base <= '0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            len_q     <= '0;
            elem_idx  <= '0;
            desc_idx  <= '0;
            a_val     <= '0;
            b_val     <= '0;
            acc       <= '0;
            result_q  <= '0;
            retry_cnt <= '0;
            cnt       <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            start_q <= control_reg[0];
            stop_q  <= control_reg[1];

            if (state_nxt == S_IDLE) stop_pend <= 1'b0;
            else if (stop_rise)      stop_pend <= 1'b1;

            if (issue) begin
                stb_q <= 1'b1;
                adr_q <= issue_adr;
                we_q  <= state == S_WR_C;
                dat_q <= (state == S_WR_C) ? result_q : '0;
            end else if (stb_q && (wb_ack_i || wb_err_i || wb_rty_i)) begin
                stb_q <= 1'b0;
            end

            if (retry_inc)    retry_cnt <= retry_cnt + RW'(1);
            else if (ack_hit) retry_cnt <= '0;

            if (accept) begin
                op_q      <= control_reg[15:8];
                desc_base <= issue_adr;
                desc_idx  <= '0;
                elem_idx  <= '0;
                acc       <= '0;
                cnt       <= '0;
                retry_cnt <= '0;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                abort_q   <= 1'b0;
            end

            if (ack_hit) begin
                case (state)
                    S_DESC: begin
                        case (desc_idx)
                            2'd0:    a_base <= aw'(wb_dat_i);
                            2'd1:    b_base <= aw'(wb_dat_i);
                            2'd2:    c_base <= aw'(wb_dat_i);
                            default: len_q  <= wb_dat_i[LEN_W-1:0];
                        endcase
                        desc_idx <= desc_idx + 2'd1;
                    end
                    S_RD_A: a_val <= wb_dat_i;
                    S_RD_B: b_val <= wb_dat_i;
                    S_WR_C: begin
                        cnt <= cnt + 16'd1;
                        if (!is_mac) elem_idx <= idx_inc;
                    end
                    default: ;
                endcase
            end

            if (do_exec) begin
                result_q <= exec_val;
                if (is_mac) begin
                    acc      <= exec_val;
                    elem_idx <= idx_inc;
                end
            end

            if (bad_op || set_err) err_q <= 1'b1;
            if (set_abort)         abort_q <= 1'b1;
            if (set_done)          done_q <= 1'b1;
        end
    end

    assign wb_cyc_o = stb_q;
    assign wb_stb_o = stb_q;
    assign wb_sel_o = stb_q ? 4'hF : 4'h0;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    // Status word: active, done, error, aborted, elements written
    always_comb begin
        status_reg        = '0;
        status_reg[0]     = state != S_IDLE;
        status_reg[1]     = done_q;
        status_reg[2]     = err_q;
        status_reg[3]     = abort_q;
        status_reg[31:16] = cnt;
    end

endmodule

// File: tb/tb_wb_dsp_vector_engine.sv
// Bench for wb_dsp_vector_engine: zero-wait Wishbone slave model with
// retry/error/hold-off knobs, and a write scoreboard per scenario.
module tb_wb_dsp_vector_engine;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o, status_reg;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic [31:0] equation_address_reg = '0;
    logic [31:0] control_reg = '0;

    always #5 wb_clk = ~wb_clk;

    wb_dsp_vector_engine dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .equation_address_reg(equation_address_reg),
        .control_reg(control_reg), .status_reg(status_reg)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    int          hold_cycles = 0;
    logic [31:0] hold_adr = '0;
    int          rty_left = 0;
    logic [31:0] rty_adr = '0;
    int          err_wr_n = 0;
    int          wr_attempts = 0;
    int          n_reads = 0, n_writes = 0, n_proto_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [31:0] issue_q[$];
    logic        prev_stb = 1'b0;
    logic [31:0] prev_adr = '0;

    // Slave model: responds in the same cycle stb is seen, unless held off
    always @(negedge wb_clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        if (wb_stb_o && !prev_stb) issue_q.push_back(wb_adr_o);
        if (wb_stb_o && prev_stb && wb_adr_o != prev_adr) n_proto_bad++;
        if (wb_stb_o && (wb_cti_o != 3'd0 || wb_bte_o != 2'd0 || wb_sel_o != 4'hF || !wb_cyc_o))
            n_proto_bad++;
        if (wb_stb_o) begin
            if (hold_cycles > 0 && wb_adr_o == hold_adr) begin
                hold_cycles--;
            end else if (rty_left > 0 && wb_adr_o == rty_adr) begin
                wb_rty_i = 1'b1;
                rty_left--;
            end else if (wb_we_o) begin
                wr_attempts++;
                if (wr_attempts == err_wr_n) begin
                    wb_err_i = 1'b1;
                end else begin
                    wb_ack_i = 1'b1;
                    mem[wb_adr_o] = wb_dat_o;
                    n_writes++;
                    obs_q.push_back({wb_adr_o, wb_dat_o});
                end
            end else begin
                wb_ack_i = 1'b1;
                wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
                n_reads++;
            end
        end
        prev_stb = wb_stb_o;
        prev_adr = wb_adr_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic slave_clear();
        hold_cycles = 0; rty_left = 0; err_wr_n = 0; wr_attempts = 0;
        n_reads = 0; n_writes = 0; n_proto_bad = 0;
        exp_q.delete(); obs_q.delete(); issue_q.delete();
    endtask

    task automatic setup_desc(input logic [31:0] d, a, b, c, len);
        mem[d] = a; mem[d + 4] = b; mem[d + 8] = c; mem[d + 12] = len;
        equation_address_reg = d;
    endtask

    task automatic kick(input logic [7:0] op, input logic with_stop);
        @(negedge wb_clk);
        control_reg = {16'h0, op, 6'h0, with_stop, 1'b1};
        @(posedge wb_clk);
        #1;
    endtask

    task automatic drop_ctrl();
        @(negedge wb_clk);
        control_reg = '0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge wb_clk);
            #1;
            if (!status_reg[0]) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        repeat (3) @(posedge wb_clk);
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o} !== 12'h0 ||
            wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || status_reg !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: cyc=%b stb=%b adr=%h dat=%h status=%h, required all zero",
                     wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, status_reg);
        end
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        repeat (2) @(posedge wb_clk);
    endtask

    task automatic test_add();
        bit to;
        logic [63:0] e, o;
        slave_clear();
        setup_desc(32'h100, 32'h1000, 32'h2000, 32'h3000, 32'd3);
        for (int i = 0; i < 3; i++) begin
            mem[32'h1000 + 4 * i] = i + 1;
            mem[32'h2000 + 4 * i] = 10 * (i + 1);
            exp_q.push_back({32'h3000 + 32'(4 * i), 32'(11 * (i + 1))});
        end
        kick(8'd0, 1'b0);
        checks++;
        if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1 || status_reg[0] !== 1'b1 || wb_adr_o !== 32'h100) begin
            errors++;
            $display("FAIL add_start_latency: stb=%b cyc=%b active=%b adr=%h, required 1 1 1 00000100",
                     wb_stb_o, wb_cyc_o, status_reg[0], wb_adr_o);
        end
        drop_ctrl();
        wait_idle(300, to);
        checks++;
        if (to) begin errors++; $display("FAIL add_timeout: still active, required idle"); end
        checks++;
        if (status_reg !== 32'h0003_0002) begin
            errors++; $display("FAIL add_status: got %h, required 00030002", status_reg);
        end
        checks++;
        if (n_reads !== 10 || n_writes !== 3 || n_proto_bad !== 0) begin
            errors++;
            $display("FAIL add_transfers: reads=%0d writes=%0d proto_bad=%0d, required 10 3 0",
                     n_reads, n_writes, n_proto_bad);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            checks++;
            if (o !== e) begin errors++; $display("FAIL add_write: got %h, required %h", o, e); end
        end
    endtask

    task automatic test_mac();
        bit to;
        logic [63:0] e, o;
        slave_clear();
        setup_desc(32'h200, 32'h1100, 32'h1100, 32'h3100, 32'd4);
        for (int i = 0; i < 4; i++) mem[32'h1100 + 4 * i] = i + 1;
        exp_q.push_back({32'h3100, 32'd30});
        kick(8'd3, 1'b0);
        drop_ctrl();
        wait_idle(300, to);
        checks++;
        if (to || status_reg !== 32'h0001_0002 || n_writes !== 1 || n_reads !== 12) begin
            errors++;
            $display("FAIL mac_status: timeout=%0d status=%h writes=%0d reads=%0d, required 0 00010002 1 12",
                     to, status_reg, n_writes, n_reads);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            checks++;
            if (o !== e) begin errors++; $display("FAIL mac_write: got %h, required %h", o, e); end
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++; $display("FAIL mac_extra_writes: got %0d extra, required 0", obs_q.size());
        end
    endtask

    task automatic test_wrap_copy();
        bit to;
        logic [63:0] e, o;
        logic [7:0]  ops [3] = '{8'd1, 8'd2, 8'd4};
        logic [31:0] av [3] = '{32'h0, 32'h0001_0000, 32'hAAAA_5555};
        logic [31:0] bv [3] = '{32'h1, 32'h0001_0000, 32'h1234_5678};
        logic [31:0] ev [3] = '{32'hFFFF_FFFF, 32'h0, 32'hAAAA_5555};
        int          rd_req [3] = '{6, 6, 5};
        for (int k = 0; k < 3; k++) begin
            slave_clear();
            setup_desc(32'h300 + 32'(16 * k), 32'h1200 + 32'(16 * k), 32'h1208 + 32'(16 * k),
                       32'h3200 + 32'(16 * k), 32'd1);
            mem[32'h1200 + 32'(16 * k)] = av[k];
            mem[32'h1208 + 32'(16 * k)] = bv[k];
            exp_q.push_back({32'h3200 + 32'(16 * k), ev[k]});
            kick(ops[k], 1'b0);
            drop_ctrl();
            wait_idle(200, to);
            checks++;
            if (to || status_reg !== 32'h0001_0002 || n_reads !== rd_req[k]) begin
                errors++;
                $display("FAIL wrap_status op%0d: timeout=%0d status=%h reads=%0d, required 0 00010002 %0d",
                         ops[k], to, status_reg, n_reads, rd_req[k]);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                checks++;
                if (o !== e) begin errors++; $display("FAIL wrap_write op%0d: got %h, required %h", ops[k], o, e); end
            end
        end
    endtask

    task automatic test_retry();
        bit to;
        int b_issues;
        logic [63:0] e, o;
        slave_clear();
        setup_desc(32'h400, 32'h1400, 32'h1500, 32'h3400, 32'd1);
        mem[32'h1400] = 32'd5;
        mem[32'h1500] = 32'd7;
        rty_adr = 32'h1500;
        rty_left = 2;
        exp_q.push_back({32'h3400, 32'd12});
        kick(8'd0, 1'b0);
        drop_ctrl();
        wait_idle(200, to);
        b_issues = 0;
        foreach (issue_q[i]) if (issue_q[i] == 32'h1500) b_issues++;
        checks++;
        if (to || status_reg !== 32'h0001_0002 || b_issues !== 3 || n_proto_bad !== 0) begin
            errors++;
            $display("FAIL retry_ok: timeout=%0d status=%h b_issues=%0d proto_bad=%0d, required 0 00010002 3 0",
                     to, status_reg, b_issues, n_proto_bad);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            checks++;
            if (o !== e) begin errors++; $display("FAIL retry_write: got %h, required %h", o, e); end
        end
        slave_clear();
        rty_left = 4;
        kick(8'd0, 1'b0);
        drop_ctrl();
        wait_idle(200, to);
        b_issues = 0;
        foreach (issue_q[i]) if (issue_q[i] == 32'h1500) b_issues++;
        checks++;
        if (to || status_reg !== 32'h0000_0004 || wb_cyc_o !== 1'b0 || n_writes !== 0 || b_issues !== 4) begin
            errors++;
            $display("FAIL retry_overflow: timeout=%0d status=%h cyc=%b writes=%0d b_issues=%0d, required 0 00000004 0 0 4",
                     to, status_reg, wb_cyc_o, n_writes, b_issues);
        end
    endtask

    task automatic test_err_stop();
        bit to;
        bit seen;
        logic [63:0] e, o;
        slave_clear();
        setup_desc(32'h500, 32'h1600, 32'h1700, 32'h3500, 32'd3);
        for (int i = 0; i < 3; i++) begin
            mem[32'h1600 + 4 * i] = 32'h100 + i;
            mem[32'h1700 + 4 * i] = 32'h1;
        end
        err_wr_n = 2;
        exp_q.push_back({32'h3500, 32'h101});
        kick(8'd0, 1'b0);
        drop_ctrl();
        wait_idle(300, to);
        checks++;
        if (to || status_reg !== 32'h0001_0004 || wb_cyc_o !== 1'b0 || n_writes !== 1) begin
            errors++;
            $display("FAIL err_write: timeout=%0d status=%h cyc=%b writes=%0d, required 0 00010004 0 1",
                     to, status_reg, wb_cyc_o, n_writes);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            checks++;
            if (o !== e) begin errors++; $display("FAIL err_scoreboard: got %h, required %h", o, e); end
        end
        slave_clear();
        setup_desc(32'h600, 32'h1800, 32'h1900, 32'h3600, 32'd2);
        hold_adr = 32'h1800;
        hold_cycles = 6;
        kick(8'd0, 1'b0);
        drop_ctrl();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge wb_clk);
            #1;
            seen = wb_stb_o && wb_adr_o == 32'h1800;
        end
        @(negedge wb_clk);
        control_reg = 32'h2;
        repeat (2) @(posedge wb_clk);
        #1;
        checks++;
        if (!seen || wb_stb_o !== 1'b1 || wb_adr_o !== 32'h1800) begin
            errors++;
            $display("FAIL stop_hold: reached=%0d stb=%b adr=%h, required 1 1 00001800", seen, wb_stb_o, wb_adr_o);
        end
        wait_idle(100, to);
        checks++;
        if (to || status_reg !== 32'h0000_0008 || wb_cyc_o !== 1'b0 || n_writes !== 0 || n_proto_bad !== 0) begin
            errors++;
            $display("FAIL stop_abort: timeout=%0d status=%h cyc=%b writes=%0d proto_bad=%0d, required 0 00000008 0 0 0",
                     to, status_reg, wb_cyc_o, n_writes, n_proto_bad);
        end
        drop_ctrl();
    endtask

    task automatic test_bad_op();
        int bus_seen;
        slave_clear();
        setup_desc(32'h700, 32'h1A00, 32'h1B00, 32'h3700, 32'd1);
        kick(8'd7, 1'b0);
        checks++;
        if (status_reg[2] !== 1'b1 || status_reg[0] !== 1'b0 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL bad_op: error=%b active=%b cyc=%b, required 1 0 0", status_reg[2], status_reg[0], wb_cyc_o);
        end
        drop_ctrl();
        kick(8'd0, 1'b1);
        drop_ctrl();
        bus_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk);
            #1;
            if (wb_cyc_o || status_reg[0]) bus_seen++;
        end
        checks++;
        if (bus_seen !== 0 || issue_q.size() !== 0) begin
            errors++;
            $display("FAIL no_bus_cycle: busy_cycles=%0d issues=%0d, required 0 0", bus_seen, issue_q.size());
        end
    endtask

    task automatic test_len0();
        bit to;
        slave_clear();
        setup_desc(32'h800, 32'h1C00, 32'h1D00, 32'h3800, 32'd0);
        kick(8'd3, 1'b0);
        drop_ctrl();
        wait_idle(100, to);
        checks++;
        if (to || status_reg !== 32'h0000_0002 || n_reads !== 4 || n_writes !== 0) begin
            errors++;
            $display("FAIL len0: timeout=%0d status=%h reads=%0d writes=%0d, required 0 00000002 4 0",
                     to, status_reg, n_reads, n_writes);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        slave_clear();
        setup_desc(32'h900, 32'h1E00, 32'h1F00, 32'h3900, 32'd3);
        kick(8'd0, 1'b0);
        drop_ctrl();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge wb_clk);
            #1;
            seen = wb_stb_o && wb_we_o;
        end
        #2;
        wb_rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || wb_sel_o !== 4'h0 ||
            wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || status_reg !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: reached_wr=%0d cyc=%b stb=%b we=%b adr=%h dat=%h status=%h, required 1 and all zero",
                     seen, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, status_reg);
        end
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        repeat (2) @(posedge wb_clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_mac();
        test_wrap_copy();
        test_retry();
        test_err_stop();
        test_bad_op();
        test_len0();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
